// File: rtl/color_to_grayscale_stream.sv
// Streaming RGB-to-grayscale converter: LANES pixels per beat, four conversion modes,
// two-stage valid/ready pipeline with full backpressure and per-line beat counting.
module color_to_grayscale_stream #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned LANES = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   mode,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         s_last,
    input  logic [LANES*PIX_W-1:0]       R_in,
    input  logic [LANES*PIX_W-1:0]       G_in,
    input  logic [LANES*PIX_W-1:0]       B_in,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,
    output logic [LANES*(PIX_W+2)-1:0]   grayscale_out,
    output logic [15:0]                  beat_cnt
);

    localparam int unsigned OUT_W  = PIX_W + 2;
    localparam int unsigned SUM_W  = PIX_W + 2;
    localparam int unsigned PROD_W = PIX_W + 8;
    localparam int unsigned ACC_W  = PIX_W + 9;
    localparam int unsigned CNT_W  = 16;

    // Per-lane unpacked views of the input and output buses
    logic [PIX_W-1:0] r_l [LANES];
    logic [PIX_W-1:0] g_l [LANES];
    logic [PIX_W-1:0] b_l [LANES];

    // Stage 1 registers
    logic              v1_q, v1_d;
    logic [1:0]        mode1_q, mode1_d;
    logic              last1_q, last1_d;
    logic [SUM_W-1:0]  sum1_q [LANES];
    logic [SUM_W-1:0]  sum1_d [LANES];
    logic [PROD_W-1:0] pr1_q  [LANES];
    logic [PROD_W-1:0] pr1_d  [LANES];
    logic [PROD_W-1:0] pg1_q  [LANES];
    logic [PROD_W-1:0] pg1_d  [LANES];
    logic [PROD_W-1:0] pb1_q  [LANES];
    logic [PROD_W-1:0] pb1_d  [LANES];
    logic [PIX_W-1:0]  max1_q [LANES];
    logic [PIX_W-1:0]  max1_d [LANES];

    // Stage 2 registers
    logic              v2_q, v2_d;
    logic              last2_q, last2_d;
    logic [OUT_W-1:0]  gray2_q [LANES];
    logic [OUT_W-1:0]  gray2_d [LANES];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic en1, en2, in_xfer, out_xfer;

    for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
        assign r_l[k] = R_in[k*PIX_W +: PIX_W];
        assign g_l[k] = G_in[k*PIX_W +: PIX_W];
        assign b_l[k] = B_in[k*PIX_W +: PIX_W];
        assign grayscale_out[k*OUT_W +: OUT_W] = gray2_q[k];
    end

    // Final per-lane selection; mode 2 rounds half-up before dropping 8 fraction bits
    function automatic logic [OUT_W-1:0] select_gray(
        input logic [1:0]        md,
        input logic [SUM_W-1:0]  sum,
        input logic [PROD_W-1:0] pr,
        input logic [PROD_W-1:0] pg,
        input logic [PROD_W-1:0] pb,
        input logic [PIX_W-1:0]  mx
    );
        logic [ACC_W-1:0] acc;
        logic [OUT_W-1:0] res;
        acc = ACC_W'(pr) + ACC_W'(pg) + ACC_W'(pb) + ACC_W'(128);
        case (md)
            2'd0:    res = OUT_W'(sum);
            2'd1:    res = OUT_W'(sum >> 2);
            2'd2:    res = OUT_W'(acc >> 8);
            default: res = OUT_W'(mx);
        endcase
        return res;
    endfunction

    // Handshake: a stage advances when it is empty or its consumer advances
    always_comb begin
        en2      = !v2_q || m_ready;
        en1      = !v1_q || en2;
        in_xfer  = s_valid && en1;
        out_xfer = v2_q && m_ready;
    end

    // Stage 1: partial sums, weighted products and channel maximum
    always_comb begin
        v1_d    = v1_q;
        mode1_d = mode1_q;
        last1_d = last1_q;
        sum1_d  = sum1_q;
        pr1_d   = pr1_q;
        pg1_d   = pg1_q;
        pb1_d   = pb1_q;
        max1_d  = max1_q;
        if (en1) begin
            v1_d = s_valid;
        end
        if (in_xfer) begin
            mode1_d = mode;
            last1_d = s_last;
            for (int unsigned k = 0; k < LANES; k++) begin
                sum1_d[k] = SUM_W'(r_l[k]) + (SUM_W'(g_l[k]) << 1) + SUM_W'(b_l[k]);
                pr1_d[k]  = PROD_W'(77)  * PROD_W'(r_l[k]);
                pg1_d[k]  = PROD_W'(150) * PROD_W'(g_l[k]);
                pb1_d[k]  = PROD_W'(29)  * PROD_W'(b_l[k]);
                max1_d[k] = (r_l[k] >= g_l[k]) ? ((r_l[k] >= b_l[k]) ? r_l[k] : b_l[k])
                                               : ((g_l[k] >= b_l[k]) ? g_l[k] : b_l[k]);
            end
        end
    end

    // Stage 2: mode selection travels with the beat, so mid-stream mode changes are per beat
    always_comb begin
        v2_d    = v2_q;
        last2_d = last2_q;
        gray2_d = gray2_q;
        cnt_d   = cnt_q;
        if (en2) begin
            v2_d = v1_q;
        end
        if (en2 && v1_q) begin
            last2_d = last1_q;
            for (int unsigned k = 0; k < LANES; k++) begin
                gray2_d[k] = select_gray(mode1_q, sum1_q[k], pr1_q[k], pg1_q[k],
                                         pb1_q[k], max1_q[k]);
            end
        end
        if (out_xfer) begin
            cnt_d = last2_q ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            mode1_q <= '0;
            last1_q <= 1'b0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            cnt_q   <= '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                sum1_q[k]  <= '0;
                pr1_q[k]   <= '0;
                pg1_q[k]   <= '0;
                pb1_q[k]   <= '0;
                max1_q[k]  <= '0;
                gray2_q[k] <= '0;
            end
        end else begin
            v1_q    <= v1_d;
            mode1_q <= mode1_d;
            last1_q <= last1_d;
            v2_q    <= v2_d;
            last2_q <= last2_d;
            cnt_q   <= cnt_d;
            sum1_q  <= sum1_d;
            pr1_q   <= pr1_d;
            pg1_q   <= pg1_d;
            pb1_q   <= pb1_d;
            max1_q  <= max1_d;
            gray2_q <= gray2_d;
        end
    end

    assign s_ready  = en1;
    assign m_valid  = v2_q;
    assign m_last   = last2_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_color_to_grayscale_stream.sv
// Directed + randomized bench for color_to_grayscale_stream; outputs are scored
// against an arithmetic reference model fed from every accepted input beat.
module tb_color_to_grayscale_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        s_valid, s_ready, s_last;
    logic [7:0]  r_in, g_in, b_in;
    logic        m_valid, m_ready, m_last;
    logic [9:0]  gray;
    logic [15:0] beat_cnt;

    logic        rst4_n;
    logic [1:0]  mode4;
    logic        s_valid4, s_ready4, s_last4;
    logic [39:0] r4, g4, b4;
    logic        m_valid4, m_ready4, m_last4;
    logic [47:0] gray4;
    logic [15:0] cnt4;

    typedef struct {
        int unsigned g;
        bit          last;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          sent = 0;
    int          rcvd = 0;
    int          last_pos = 0;
    int unsigned exp_cnt = 0;

    always #5 clk = ~clk;

    color_to_grayscale_stream #(.PIX_W(8), .LANES(1)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .R_in(r_in), .G_in(g_in), .B_in(b_in), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .grayscale_out(gray), .beat_cnt(beat_cnt)
    );

    color_to_grayscale_stream #(.PIX_W(10), .LANES(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .mode(mode4), .s_valid(s_valid4), .s_ready(s_ready4),
        .s_last(s_last4), .R_in(r4), .G_in(g4), .B_in(b4), .m_valid(m_valid4),
        .m_ready(m_ready4), .m_last(m_last4), .grayscale_out(gray4), .beat_cnt(cnt4)
    );

    function automatic int unsigned ref_gray(int unsigned md, int unsigned r,
                                             int unsigned g, int unsigned b);
        case (md)
            0:       return r + 2*g + b;
            1:       return (r + 2*g + b) / 4;
            2:       return (77*r + 150*g + 29*b + 128) / 256;
            default: return (r > g) ? ((r > b) ? r : b) : ((g > b) ? g : b);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes seen before the edge, then check stall stability after it
    task automatic tick();
        exp_t       e;
        logic       hold;
        logic [9:0] hg;
        logic       hl;
        #1;
        if (s_valid && s_ready) begin
            sb.push_back('{ref_gray(mode, r_in, g_in, b_in), s_last});
            sent++;
        end
        if (m_valid && m_ready) begin
            rcvd++;
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL extra_output observed=%0d expected=none", gray);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("gray", gray, e.g);
                chk("m_last", m_last, e.last);
                chk("beat_cnt", beat_cnt, exp_cnt);
                exp_cnt = e.last ? 0 : (exp_cnt + 1) % 65536;
                if (e.last) last_pos = rcvd;
            end
        end
        hold = m_valid && !m_ready;
        hg   = gray;
        hl   = m_last;
        @(posedge clk);
        #1;
        if (hold) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_gray", gray, hg);
            chk("hold_last", m_last, hl);
        end
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        chk("drained", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        exp_cnt = 0;
    endtask

    task automatic directed(input string tag, input int unsigned md, input int unsigned r,
                            input int unsigned g, input int unsigned b, input int unsigned expv);
        mode    = 2'(md);
        r_in    = 8'(r);
        g_in    = 8'(g);
        b_in    = 8'(b);
        s_last  = 1'b0;
        s_valid = 1'b1;
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        chk({tag, "_lat1"}, m_valid, 0);
        tick();
        chk({tag, "_lat2"}, m_valid, 1);
        chk(tag, gray, expv);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; mode = '0; s_valid = 1'b1; s_last = 1'b0;
        r_in = 8'd10; g_in = 8'd20; b_in = 8'd30; m_ready = 1'b1;
        rst4_n = 1'b0; mode4 = '0; s_valid4 = 1'b0; s_last4 = 1'b0;
        r4 = '0; g4 = '0; b4 = '0; m_ready4 = 1'b1;

        // Reset held three cycles with s_valid asserted
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_gray", gray, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_m_last", m_last, 0);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        rst4_n  = 1'b1;
        #1;
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;

        // Conversion modes with spec reference values
        directed("m0_white", 0, 255, 255, 255, 1020);
        directed("m1_white", 1, 255, 255, 255, 255);
        directed("m2_white", 2, 255, 255, 255, 255);
        directed("m3_white", 3, 255, 255, 255, 255);
        directed("m0_mix", 0, 200, 100, 50, 450);
        directed("m1_mix", 1, 200, 100, 50, 112);
        directed("m2_mix", 2, 200, 100, 50, 124);
        directed("m3_mix", 3, 200, 100, 50, 200);
        directed("m3_bmax", 3, 3, 7, 9, 9);

        // Mode alternating 0/2 on back-to-back beats
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mode = (i % 2 == 1) ? 2'd2 : 2'd0;
            r_in = 8'($urandom_range(0, 255));
            g_in = 8'($urandom_range(0, 255));
            b_in = 8'($urandom_range(0, 255));
            tick();
        end
        drain();

        // Backpressure: 10 random beats, output stalled for cycles 3..7
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (sent == 10 && sb.size() == 0) break;
            m_ready = !(cyc >= 3 && cyc <= 7);
            s_valid = (sent < 10);
            mode = 2'($urandom_range(0, 3));
            r_in = 8'($urandom_range(0, 255));
            g_in = 8'($urandom_range(0, 255));
            b_in = 8'($urandom_range(0, 255));
            if (cyc == 5) begin
                #1;
                chk("bp_s_ready", s_ready, 0);
                chk("bp_m_valid", m_valid, 1);
            end
            tick();
        end
        chk("bp_sent", sent, 10);
        chk("bp_rcvd", rcvd, 10);
        drain();

        // Random stress with random valid/ready/last
        for (int cyc = 0; cyc < 300; cyc++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            m_ready = ($urandom_range(0, 9) < 6);
            s_last  = ($urandom_range(0, 4) == 0);
            mode = 2'($urandom_range(0, 3));
            r_in = 8'($urandom_range(0, 255));
            g_in = 8'($urandom_range(0, 255));
            b_in = 8'($urandom_range(0, 255));
            tick();
        end
        s_last = 1'b0;
        drain();

        // Five-beat line after a fresh reset
        do_reset();
        rcvd = 0;
        last_pos = 0;
        sent = 0;
        m_ready = 1'b1;
        mode = 2'd1;
        for (int cyc = 0; cyc < 20 && (sent < 5 || sb.size() != 0); cyc++) begin
            s_valid = (sent < 5);
            s_last  = (sent == 4);
            r_in = 8'($urandom_range(0, 255));
            g_in = 8'($urandom_range(0, 255));
            b_in = 8'($urandom_range(0, 255));
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("line_rcvd", rcvd, 5);
        chk("line_last_pos", last_pos, 5);
        chk("line_cnt_end", beat_cnt, 0);

        // Four lanes of 10-bit pixels, mode 0
        r4 = {10'd512, 10'd1, 10'd0, 10'd1023};
        g4 = {10'd0,   10'd2, 10'd0, 10'd1023};
        b4 = {10'd0,   10'd3, 10'd0, 10'd1023};
        mode4 = 2'd0;
        s_valid4 = 1'b1;
        m_ready4 = 1'b1;
        #1;
        chk("ml_s_ready", s_ready4, 1);
        @(posedge clk);
        #1;
        s_valid4 = 1'b0;
        chk("ml_lat1", m_valid4, 0);
        @(posedge clk);
        #1;
        chk("ml_valid", m_valid4, 1);
        begin
            int unsigned ml_exp [4] = '{4092, 0, 8, 512};
            for (int k = 0; k < 4; k++) chk("ml_lane", gray4[k*12 +: 12], ml_exp[k]);
        end
        chk("ml_cnt", cnt4, 0);

        // Reset with both stages of the 4-lane instance full
        m_ready4 = 1'b0;
        s_valid4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("ml_full_s_ready", s_ready4, 0);
        rst4_n = 1'b0;
        @(posedge clk);
        #1;
        chk("ml_rst_valid", m_valid4, 0);
        chk("ml_rst_gray", gray4, 0);
        chk("ml_rst_last", m_last4, 0);
        rst4_n = 1'b1;
        s_valid4 = 1'b0;
        #1;
        chk("ml_rst_s_ready", s_ready4, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
